decode_round_scheduler: RTL and testbench

Front-end scheduler for the single-FPGA Helios decoder. Accepts syndrome data one measurement layer (CODE_DISTANCE_X × CODE_DISTANCE_Z bits) per handshake and assembles full frames of MEASUREMENT_ROUNDS layers into a two-entry ping-pong buffer. It dispatches each completed frame to the decoder top with a single-cycle `new_round_start`, holds the measurements stable while the decoder runs, and returns per-frame statistics on a valid/ready result port.

---
 rtl/helios_sched_pkg.sv | 27 ++
 rtl/frame_pingpong_buffer.sv | 58 +++++
 rtl/decode_round_scheduler.sv | 151 +++++++++++++++
 tb/tb_decode_round_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_sched_pkg.sv
// Shared types and geometry helpers for the Helios decode round scheduler.
// Optional watchdog is enabled with the HELIOS_SCHED_WATCHDOG_EN macro.
package helios_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    CLEAR,
    WAIT,
    REPORT
  } sched_state_t;

  localparam logic [7:0] TIMEOUT_ITERATIONS = 8'hFF;

  function automatic int measurement_rounds(input int dist_x, input int dist_z);
    return (dist_x > dist_z) ? dist_x : dist_z;
  endfunction

  function automatic int layer_width(input int dist_x, input int dist_z);
    return dist_x * dist_z;
  endfunction

  function automatic int pu_count(input int dist_x, input int dist_z);
    return dist_x * dist_z * measurement_rounds(dist_x, dist_z);
  endfunction

endpackage

// File: rtl/frame_pingpong_buffer.sv
// Two-entry frame store: layers fill one frame while the other is held for dispatch.
module frame_pingpong_buffer #(
  parameter int  LAYER_W = 20,
  parameter int  ROUNDS  = 5,
  localparam int FRAME_W = LAYER_W * ROUNDS,
  localparam int IDX_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_en,
  input  logic [LAYER_W-1:0] i_wr_data,
  input  logic               i_free,
  output logic               o_fill_empty,
  output logic [1:0]         o_full_count,
  output logic [FRAME_W-1:0] o_disp_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  logic [FRAME_W-1:0] r_frame [2];
  logic [1:0]         r_full;
  logic               r_fill_ptr;
  logic               r_disp_ptr;
  logic [IDX_W-1:0]   r_layer_idx;

  // Writes only ever target an empty buffer and frees only a full one, so the
  // two pointers never collide on the same full flag in one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame[0]  <= '0;
      r_frame[1]  <= '0;
      r_full      <= '0;
      r_fill_ptr  <= 1'b0;
      r_disp_ptr  <= 1'b0;
      r_layer_idx <= '0;
    end else begin
      if (i_wr_en) begin
        r_frame[r_fill_ptr][r_layer_idx*LAYER_W +: LAYER_W] <= i_wr_data;
        if (r_layer_idx == LAST_IDX) begin
          r_full[r_fill_ptr] <= 1'b1;
          r_fill_ptr         <= ~r_fill_ptr;
          r_layer_idx        <= '0;
        end else begin
          r_layer_idx <= r_layer_idx + 1'b1;
        end
      end
      if (i_free) begin
        r_full[r_disp_ptr] <= 1'b0;
        r_disp_ptr         <= ~r_disp_ptr;
      end
    end
  end

  assign o_fill_empty = ~r_full[r_fill_ptr];
  assign o_full_count = 2'(r_full[0]) + 2'(r_full[1]);
  assign o_disp_data  = r_frame[r_disp_ptr];

endmodule

// File: rtl/decode_round_scheduler.sv
// Dispatches buffered syndrome frames to the decoder and reports per-frame results.
// Define HELIOS_SCHED_WATCHDOG_EN to abort frames the decoder never finishes.
module decode_round_scheduler
  import helios_sched_pkg::*;
#(
  parameter int  CODE_DISTANCE_X = 5,
  parameter int  CODE_DISTANCE_Z = 4,
  parameter int  TIMEOUT_CYCLES  = 4096,
  localparam int ROUNDS   = measurement_rounds(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int LAYER_W  = layer_width(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int PU_COUNT = pu_count(CODE_DISTANCE_X, CODE_DISTANCE_Z)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                layer_valid,
  output logic                layer_ready,
  input  logic [LAYER_W-1:0]  layer_data,
  output logic                dec_new_round_start,
  output logic [PU_COUNT-1:0] dec_measurements,
  input  logic                dec_result_valid,
  input  logic [7:0]          dec_iteration_counter,
  input  logic [31:0]         dec_cycle_counter,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [7:0]          done_frame_id,
  output logic [7:0]          done_iterations,
  output logic [31:0]         done_cycles,
  output logic                done_timeout
);

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  sched_state_t r_state;
  logic         r_start;
  logic         r_done_valid;
  logic         r_done_timeout;
  logic [7:0]   r_frame_id;
  logic [7:0]   r_iterations;
  logic [31:0]  r_cycles;

  logic         w_fill_empty;
  logic [1:0]   w_full_count;
  logic         w_accept;
  logic         w_free;
  logic         w_wd_expired;
  logic [31:0]  w_wd_next;

  assign w_accept = layer_valid && w_fill_empty;
  assign w_free   = (r_state == REPORT) && done_ready;

  frame_pingpong_buffer #(
    .LAYER_W (LAYER_W),
    .ROUNDS  (ROUNDS)
  ) u_buffer (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_accept),
    .i_wr_data    (layer_data),
    .i_free       (w_free),
    .o_fill_empty (w_fill_empty),
    .o_full_count (w_full_count),
    .o_disp_data  (dec_measurements)
  );

`ifdef HELIOS_SCHED_WATCHDOG_EN
  logic [31:0] r_wd_count;

  assign w_wd_next    = r_wd_count + 32'd1;
  assign w_wd_expired = ((r_state == CLEAR) || (r_state == WAIT)) && (w_wd_next == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset || (r_state == START)) begin
      r_wd_count <= '0;
    end else if ((r_state == CLEAR) || (r_state == WAIT)) begin
      r_wd_count <= w_wd_next;
    end
  end
`else
  // Without the watchdog the timeout branch below can never be taken.
  assign w_wd_next    = TIMEOUT_LIMIT;
  assign w_wd_expired = 1'b0;
`endif

  // CLEAR exists to let the previous frame's result_valid fall before WAIT
  // starts looking for a fresh result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_start        <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_timeout <= 1'b0;
      r_frame_id     <= '0;
      r_iterations   <= '0;
      r_cycles       <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_full_count != 2'd0) begin
            r_state <= START;
            r_start <= 1'b1;
          end
        end
        START: r_state <= CLEAR;
        CLEAR: begin
          if (w_wd_expired) begin
            r_state        <= REPORT;
            r_done_valid   <= 1'b1;
            r_done_timeout <= 1'b1;
            r_iterations   <= TIMEOUT_ITERATIONS;
            r_cycles       <= w_wd_next;
          end else if (!dec_result_valid) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (dec_result_valid) begin
            r_state        <= REPORT;
            r_done_valid   <= 1'b1;
            r_done_timeout <= 1'b0;
            r_iterations   <= dec_iteration_counter;
            r_cycles       <= dec_cycle_counter;
          end else if (w_wd_expired) begin
            r_state        <= REPORT;
            r_done_valid   <= 1'b1;
            r_done_timeout <= 1'b1;
            r_iterations   <= TIMEOUT_ITERATIONS;
            r_cycles       <= w_wd_next;
          end
        end
        REPORT: begin
          if (done_ready) begin
            r_state      <= IDLE;
            r_done_valid <= 1'b0;
            r_frame_id   <= r_frame_id + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign layer_ready         = w_fill_empty;
  assign dec_new_round_start = r_start;
  assign done_valid          = r_done_valid;
  assign done_frame_id       = r_frame_id;
  assign done_iterations     = r_iterations;
  assign done_cycles         = r_cycles;
  assign done_timeout        = r_done_timeout;

endmodule

// File: tb/tb_decode_round_scheduler.sv
// Self-checking bench for decode_round_scheduler with a behavioural decoder model.
`timescale 1ns/1ps
module tb_decode_round_scheduler;
  import helios_sched_pkg::*;

  localparam int X      = 5;
  localparam int Z      = 4;
  localparam int TMO    = 16;
  localparam int ROUNDS = measurement_rounds(X, Z);
  localparam int LW     = layer_width(X, Z);
  localparam int PU     = pu_count(X, Z);
  localparam int BUDGET = 3000;
`ifdef HELIOS_SCHED_WATCHDOG_EN
  localparam int LONG_LAT = 10;
`else
  localparam int LONG_LAT = 100;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          layer_valid = 1'b0;
  logic          layer_ready;
  logic [LW-1:0] layer_data = '0;
  logic          dec_new_round_start;
  logic [PU-1:0] dec_measurements;
  logic          dec_result_valid;
  logic [7:0]    dec_iteration_counter;
  logic [31:0]   dec_cycle_counter;
  logic          done_valid;
  logic          done_ready;
  logic [7:0]    done_frame_id;
  logic [7:0]    done_iterations;
  logic [31:0]   done_cycles;
  logic          done_timeout;

  always #5 clk = ~clk;

  decode_round_scheduler #(
    .CODE_DISTANCE_X (X),
    .CODE_DISTANCE_Z (Z),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .layer_valid           (layer_valid),
    .layer_ready           (layer_ready),
    .layer_data            (layer_data),
    .dec_new_round_start   (dec_new_round_start),
    .dec_measurements      (dec_measurements),
    .dec_result_valid      (dec_result_valid),
    .dec_iteration_counter (dec_iteration_counter),
    .dec_cycle_counter     (dec_cycle_counter),
    .done_valid            (done_valid),
    .done_ready            (done_ready),
    .done_frame_id         (done_frame_id),
    .done_iterations       (done_iterations),
    .done_cycles           (done_cycles),
    .done_timeout          (done_timeout)
  );

  typedef struct {
    logic [PU-1:0] frame;
    logic [7:0]    expId;
    logic [7:0]    iter;
    logic [31:0]   cycles;
    int            latency;
    int            stale;
    int            hold;
    bit            expectReadyLow;
    bit            drainAfter;
  } vec_t;

  typedef struct {
    logic [PU-1:0] frame;
    logic [7:0]    iter;
    logic [31:0]   cycles;
    int            latency;
    int            stale;
    bit            never;
  } resp_t;

  typedef struct {
    logic [7:0]    id;
    logic [7:0]    iter;
    logic [31:0]   cycles;
    logic          timeout;
    logic [PU-1:0] frame;
    int            hold;
  } exp_t;

  resp_t respQ[$];
  exp_t  expQ[$];
  int    checks = 0;
  int    failures = 0;
  int    badStarts = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PU-1:0] randFrame();
    logic [127:0] t;
    for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
    return t[PU-1:0];
  endfunction

  task automatic sendLayer(input logic [LW-1:0] d);
    int n = 0;
    layer_data  = d;
    layer_valid = 1'b1;
    while (!layer_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!layer_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL layer_ready_wait: ready stayed 0 for %0d cycles, required 1", n);
      layer_valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      layer_valid = 1'b0;
    end
  endtask

  // Registers the expected decoder response and result, then streams the layers.
  task automatic applyStimulus(input logic [PU-1:0] frame, input logic [7:0] id,
                               input logic [7:0] iter, input logic [31:0] cycles,
                               input int latency, input int stale, input bit never,
                               input int hold);
    respQ.push_back('{frame: frame, iter: iter, cycles: cycles, latency: latency,
                      stale: stale, never: never});
    expQ.push_back('{id: id, iter: never ? 8'hFF : iter,
                     cycles: never ? 32'(TMO) : cycles, timeout: never,
                     frame: frame, hold: hold});
    for (int r = 0; r < ROUNDS; r++) sendLayer(frame[r*LW +: LW]);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || respQ.size() != 0 || done_valid) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({"drain_", name}, 128'(expQ.size() + respQ.size()), 128'd0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_layer_ready"}, layer_ready, 1);
    checkOutput({tag, "_start"}, dec_new_round_start, 0);
    checkOutput({tag, "_measurements"}, dec_measurements, 0);
    checkOutput({tag, "_done_valid"}, done_valid, 0);
    checkOutput({tag, "_frame_id"}, done_frame_id, 0);
    checkOutput({tag, "_iterations"}, done_iterations, 0);
    checkOutput({tag, "_cycles"}, done_cycles, 0);
    checkOutput({tag, "_timeout"}, done_timeout, 0);
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b0;
    expQ.delete();
    respQ.delete();
    @(negedge clk);
    checkResetState(tag);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Decoder model: holds result_valid high until the next start (optionally
  // for extra stale cycles), then answers after the configured latency.
  initial begin
    resp_t r;
    int    count;
    int    staleLeft;
    bit    busy;
    count = 0;
    staleLeft = 0;
    busy = 1'b0;
    r = '{frame: '0, iter: 8'h00, cycles: 32'h0, latency: 0, stale: 0, never: 1'b0};
    dec_result_valid = 1'b0;
    dec_iteration_counter = 8'h00;
    dec_cycle_counter = 32'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dec_result_valid = 1'b0;
        busy = 1'b0;
        staleLeft = 0;
      end else begin
        if (done_valid && dec_new_round_start) badStarts++;
        if (dec_new_round_start) begin
          if (respQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_start: start pulse with no frame pending, required none");
          end else begin
            r = respQ.pop_front();
            checkOutput("dispatch_measurements", dec_measurements, r.frame);
            busy = 1'b1;
            count = r.latency;
            staleLeft = r.stale;
            if (staleLeft == 0) dec_result_valid = 1'b0;
          end
        end else if (staleLeft > 0) begin
          staleLeft--;
          if (staleLeft == 0) dec_result_valid = 1'b0;
        end else if (busy && !r.never) begin
          if (count > 1) begin
            count--;
          end else begin
            dec_result_valid = 1'b1;
            dec_iteration_counter = r.iter;
            dec_cycle_counter = r.cycles;
            busy = 1'b0;
          end
        end
      end
    end
  end

  // Result consumer: compares against the scoreboard, optionally stalling.
  initial begin
    exp_t        e;
    bit          have;
    bit          stable;
    int          holdLeft;
    logic [47:0] snap;
    have = 1'b0;
    stable = 1'b1;
    holdLeft = 0;
    snap = '0;
    done_ready = 1'b0;
    forever begin
      @(negedge clk);
      done_ready = 1'b0;
      if (!reset) begin
        have = 1'b0;
      end else if (done_valid) begin
        if (!have && expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: id %0h with no result pending, required none", done_frame_id);
          done_ready = 1'b1;
        end else begin
          if (!have) begin
            e = expQ[0];
            have = 1'b1;
            holdLeft = e.hold;
            stable = 1'b1;
            snap = {done_frame_id, done_iterations, done_cycles};
          end
          if (holdLeft > 0) begin
            holdLeft--;
            if (snap != {done_frame_id, done_iterations, done_cycles}) stable = 1'b0;
            if (holdLeft == 0) checkOutput("done_stable_under_backpressure", stable, 1);
          end else begin
            checkOutput("done_frame_id", done_frame_id, e.id);
            checkOutput("done_iterations", done_iterations, e.iter);
            checkOutput("done_cycles", done_cycles, e.cycles);
            checkOutput("done_timeout", done_timeout, e.timeout);
            checkOutput("measurements_held", dec_measurements, e.frame);
            void'(expQ.pop_front());
            have = 1'b0;
            done_ready = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vec_t          vecs [6];
    logic [PU-1:0] f;

    vecs[0] = '{frame: randFrame(), expId: 8'd1, iter: 8'd10, cycles: 32'd100, latency: LONG_LAT,
                stale: 0, hold: 0, expectReadyLow: 1'b0, drainAfter: 1'b0};
    vecs[1] = '{frame: randFrame(), expId: 8'd2, iter: 8'd11, cycles: 32'd101, latency: LONG_LAT,
                stale: 0, hold: 0, expectReadyLow: 1'b1, drainAfter: 1'b0};
    vecs[2] = '{frame: randFrame(), expId: 8'd3, iter: 8'd12, cycles: 32'd102, latency: LONG_LAT,
                stale: 0, hold: 0, expectReadyLow: 1'b0, drainAfter: 1'b1};
    vecs[3] = '{frame: randFrame(), expId: 8'd4, iter: 8'd7, cycles: 32'd123, latency: 4,
                stale: 3, hold: 0, expectReadyLow: 1'b0, drainAfter: 1'b1};
    vecs[4] = '{frame: randFrame(), expId: 8'd5, iter: 8'd21, cycles: 32'hDEAD_BEEF, latency: 5,
                stale: 0, hold: 50, expectReadyLow: 1'b0, drainAfter: 1'b0};
    vecs[5] = '{frame: randFrame(), expId: 8'd6, iter: 8'd22, cycles: 32'd77, latency: 5,
                stale: 0, hold: 0, expectReadyLow: 1'b1, drainAfter: 1'b1};

    repeat (3) @(negedge clk);
    checkResetState("por");
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] single frame with start timing");
    f = randFrame();
    applyStimulus(f, 8'd0, 8'd3, 32'd40, 5, 0, 1'b0, 0);
    checkOutput("start_not_yet", dec_new_round_start, 0);
    @(negedge clk);
    checkOutput("start_at_t2", dec_new_round_start, 1);
    waitDrain("single");

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].frame, vecs[i].expId, vecs[i].iter, vecs[i].cycles,
                    vecs[i].latency, vecs[i].stale, 1'b0, vecs[i].hold);
      if (vecs[i].expectReadyLow) checkOutput($sformatf("ready_low_vec%0d", i), layer_ready, 0);
      if (vecs[i].drainAfter) waitDrain($sformatf("vec%0d", i));
    end
    checkOutput("no_start_during_report", 128'(badStarts), 128'd0);

`ifdef HELIOS_SCHED_WATCHDOG_EN
    $display("[TB] watchdog timeout");
    applyStimulus(randFrame(), 8'd7, 8'd0, 32'd0, 0, 0, 1'b1, 0);
    applyStimulus(randFrame(), 8'd8, 8'd5, 32'd55, 4, 0, 1'b0, 0);
    waitDrain("watchdog");
`endif

    $display("[TB] reset mid-fill and mid-decode");
    f = randFrame();
    sendLayer(f[0 +: LW]);
    sendLayer(f[LW +: LW]);
    pulseReset("reset_mid_fill");
    f = randFrame();
    applyStimulus(f, 8'd0, 8'd9, 32'd99, 12, 0, 1'b0, 0);
    repeat (8) @(negedge clk);
    checkOutput("dispatched_before_reset", dec_measurements, f);
    pulseReset("reset_mid_wait");
    applyStimulus(randFrame(), 8'd0, 8'd11, 32'd77, 4, 0, 1'b0, 0);
    waitDrain("after_reset");

    $display("[TB] frame id wrap");
    for (int k = 1; k <= 256; k++) begin
      applyStimulus(randFrame(), 8'(k), 8'(k + 1), 32'(k * 3), 3, 0, 1'b0, 0);
    end
    waitDrain("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
